placar_ataque: RTL and testbench

Attack-phase scoreboard and turn controller. Sits directly downstream of the attack decoder/comparator stage. It consumes the raw fire button, the attack-mode switches, the selected cell coordinate and the hit/miss lines, and turns them into one debounced shot per press. It rejects invalid and repeated cells, counts hits and remaining shots, and declares victory or defeat for the LED/display layer.

---
 rtl/placar_ataque_if.sv | 24 ++
 rtl/placar_ataque.sv | 151 +++++++++++++++
 tb/tb_placar_ataque.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/placar_ataque_if.sv
// Bus bundle for the attack-phase scoreboard: fire button, mode/coordinate switches,
// comparator results in; score counters, shot pulses and end-of-game LEDs out.
interface placar_ataque_if;
  logic       botao;
  logic       ch7, ch6, ch5, ch4, ch3, ch2, ch1, ch0;
  logic       verde;
  logic       vermelho;
  logic [5:0] acertos;
  logic [5:0] tiros_restantes;
  logic       tiro_valido;
  logic       tiro_invalido;
  logic       led_vitoria;
  logic       led_derrota;

  modport slave (
    input  botao, ch7, ch6, ch5, ch4, ch3, ch2, ch1, ch0, verde, vermelho,
    output acertos, tiros_restantes, tiro_valido, tiro_invalido, led_vitoria, led_derrota
  );

  modport master (
    output botao, ch7, ch6, ch5, ch4, ch3, ch2, ch1, ch0, verde, vermelho,
    input  acertos, tiros_restantes, tiro_valido, tiro_invalido, led_vitoria, led_derrota
  );
endinterface

// File: rtl/placar_ataque.sv
// Attack-phase scoreboard: debounces the fire button into one shot per press,
// rejects bad/repeated cells, counts hits and remaining shots, declares win/loss.
module placar_ataque #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_TIROS       = 20,
  parameter int TOTAL_ALVOS     = 6
) (
  input  logic            clk,
  input  logic            reset,
  placar_ataque_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {OCIOSO, JOGANDO, VITORIA, DERROTA} estado_t;

  estado_t       state_q, state_d;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          disparo_q, disparo_d;

  logic [5:0]    acertos_q, acertos_d;
  logic [5:0]    tiros_q, tiros_d;
  logic [34:0]   disparados_q, disparados_d;
  logic          tiro_valido_q, tiro_valido_d;
  logic          tiro_invalido_q, tiro_invalido_d;

  logic          led_vitoria, led_derrota;

  logic [2:0]    col, lin;
  logic [5:0]    idx;
  logic [63:0]   hist_ext;
  logic          coord_ok, repetido, attack, hit, tiro_ok, tiro_nok;

  // Input path. armed_q stays low until the synchronizer has refilled after reset
  // and shown a real low level, so a press held across reset is never accepted.
  always_comb begin
    sync1_d   = bus.botao;
    sync2_d   = sync1_q;
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & ~sync2_q);
    cnt_d     = '0;
    if (sync2_q && armed_q) begin
      cnt_d = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    end
    disparo_d = sync2_q & armed_q & (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  end

  always_comb begin
    col      = {bus.ch5, bus.ch4, bus.ch3};
    lin      = {bus.ch2, bus.ch1, bus.ch0};
    attack   = bus.ch7 & bus.ch6;
    coord_ok = (col <= 3'd4) && (lin <= 3'd6);
    idx      = 6'(lin) * 6'd5 + 6'(col);
    hist_ext = {29'b0, disparados_q};
    repetido = hist_ext[idx];
    case ({bus.verde, bus.vermelho})
      2'b10, 2'b11: hit = 1'b1;
      default:      hit = 1'b0;
    endcase
    tiro_ok  = (state_q == JOGANDO) & attack & disparo_q & coord_ok & ~repetido;
    tiro_nok = (state_q == JOGANDO) & attack & disparo_q & ~(coord_ok & ~repetido);
  end

  always_comb begin
    acertos_d       = acertos_q;
    tiros_d         = tiros_q;
    disparados_d    = disparados_q;
    tiro_valido_d   = tiro_ok;
    tiro_invalido_d = tiro_nok;
    if (tiro_ok) begin
      disparados_d = disparados_q | (35'd1 << idx);
      tiros_d      = tiros_q - 6'd1;
      if (hit) begin
        acertos_d = acertos_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      fill_q          <= '0;
      armed_q         <= 1'b0;
      cnt_q           <= '0;
      disparo_q       <= 1'b0;
      acertos_q       <= '0;
      tiros_q         <= 6'(MAX_TIROS);
      disparados_q    <= '0;
      tiro_valido_q   <= 1'b0;
      tiro_invalido_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      fill_q          <= fill_d;
      armed_q         <= armed_d;
      cnt_q           <= cnt_d;
      disparo_q       <= disparo_d;
      acertos_q       <= acertos_d;
      tiros_q         <= tiros_d;
      disparados_q    <= disparados_d;
      tiro_valido_q   <= tiro_valido_d;
      tiro_invalido_q <= tiro_invalido_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OCIOSO;
    end else begin
      state_q <= state_d;
    end
  end

  // Victory is tested first so a winning hit on the last shot is not a loss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO: begin
        if (attack) state_d = JOGANDO;
      end
      JOGANDO: begin
        if (!attack) begin
          state_d = OCIOSO;
        end else if (tiro_ok) begin
          if (acertos_d == 6'(TOTAL_ALVOS)) state_d = VITORIA;
          else if (tiros_d == 6'd0)         state_d = DERROTA;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    led_vitoria = (state_q == VITORIA);
    led_derrota = (state_q == DERROTA);
  end

  assign bus.acertos         = acertos_q;
  assign bus.tiros_restantes = tiros_q;
  assign bus.tiro_valido     = tiro_valido_q;
  assign bus.tiro_invalido   = tiro_invalido_q;
  assign bus.led_vitoria     = led_vitoria;
  assign bus.led_derrota     = led_derrota;

endmodule

// File: tb/tb_placar_ataque.sv
// Scoreboard bench for placar_ataque: presses queue their expected response, a
// negedge monitor checks every tiro_valido/tiro_invalido pulse against the queue.
module tb_placar_ataque;

  logic clk;
  logic reset;

  placar_ataque_if bus ();

  placar_ataque #(
    .DEBOUNCE_CYCLES(4),
    .MAX_TIROS      (3),
    .TOTAL_ALVOS    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       valido;
    logic [5:0] acertos;
    logic [5:0] tiros;
    logic       vitoria;
    logic       derrota;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic v, input int ac, input int ti, input logic vit, input logic der);
    exp_t e;
    e.valido  = v;
    e.acertos = 6'(ac);
    e.tiros   = 6'(ti);
    e.vitoria = vit;
    e.derrota = der;
    exp_q.push_back(e);
  endtask

  // Any pulse without a queued expectation (including a pulse lasting two cycles) is flagged.
  always @(negedge clk) begin
    if (!reset && (bus.tiro_valido || bus.tiro_invalido)) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_pulse", {30'b0, bus.tiro_valido, bus.tiro_invalido}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("pulse_kind", {30'b0, bus.tiro_valido, bus.tiro_invalido}, {30'b0, e.valido, ~e.valido});
        check_output("acertos", bus.acertos, e.acertos);
        check_output("tiros_restantes", bus.tiros_restantes, e.tiros);
        check_output("led_vitoria", bus.led_vitoria, e.vitoria);
        check_output("led_derrota", bus.led_derrota, e.derrota);
      end
    end
  end

  task automatic set_coord(input logic [2:0] col, input logic [2:0] lin, input logic v);
    {bus.ch5, bus.ch4, bus.ch3} = col;
    {bus.ch2, bus.ch1, bus.ch0} = lin;
    bus.verde    = v;
    bus.vermelho = ~v;
  endtask

  task automatic apply_stimulus(input logic [2:0] col, input logic [2:0] lin, input logic v, input int hold);
    set_coord(col, lin, v);
    bus.botao = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.botao = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int ac, input int ti, input logic vit, input logic der);
    check_output({tag, "_acertos"}, bus.acertos, ac);
    check_output({tag, "_tiros"}, bus.tiros_restantes, ti);
    check_output({tag, "_vitoria"}, bus.led_vitoria, vit);
    check_output({tag, "_derrota"}, bus.led_derrota, der);
    check_output({tag, "_pendentes"}, exp_q.size(), 0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.botao = 1'b0;
    bus.ch7   = 1'b0;
    bus.ch6   = 1'b0;
    set_coord(3'd0, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_state("reset", 0, 3, 1'b0, 1'b0);
    check_output("reset_pulses", {30'b0, bus.tiro_valido, bus.tiro_invalido}, 0);
    @(posedge clk);
    #1;
    bus.ch7 = 1'b1;
    bus.ch6 = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Hit, repeat, bad column, bad line
    push_exp(1'b1, 1, 2, 1'b0, 1'b0);
    apply_stimulus(3'd1, 3'd2, 1'b1, 10);
    push_exp(1'b0, 1, 2, 1'b0, 1'b0);
    apply_stimulus(3'd1, 3'd2, 1'b1, 10);
    push_exp(1'b0, 1, 2, 1'b0, 1'b0);
    apply_stimulus(3'd5, 3'd2, 1'b1, 10);
    push_exp(1'b0, 1, 2, 1'b0, 1'b0);
    apply_stimulus(3'd1, 3'd7, 1'b1, 10);
    check_state("invalidos", 1, 2, 1'b0, 1'b0);

    // Defeat: miss, miss, hit, then an ignored fourth press
    do_reset();
    push_exp(1'b1, 0, 2, 1'b0, 1'b0);
    apply_stimulus(3'd0, 3'd0, 1'b0, 10);
    push_exp(1'b1, 0, 1, 1'b0, 1'b0);
    apply_stimulus(3'd1, 3'd0, 1'b0, 10);
    push_exp(1'b1, 1, 0, 1'b0, 1'b1);
    apply_stimulus(3'd2, 3'd0, 1'b1, 10);
    apply_stimulus(3'd3, 3'd0, 1'b1, 10);
    check_state("derrota", 1, 0, 1'b0, 1'b1);

    // Victory on the last shot takes priority over defeat
    do_reset();
    push_exp(1'b1, 1, 2, 1'b0, 1'b0);
    apply_stimulus(3'd0, 3'd0, 1'b1, 10);
    push_exp(1'b1, 1, 1, 1'b0, 1'b0);
    apply_stimulus(3'd1, 3'd0, 1'b0, 10);
    push_exp(1'b1, 2, 0, 1'b1, 1'b0);
    apply_stimulus(3'd2, 3'd0, 1'b1, 10);
    check_state("vitoria", 2, 0, 1'b1, 1'b0);

    // Short glitches are filtered; a 6-cycle press on the last cell (E, line 6) counts
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_coord(3'd2, 3'd2, 1'b1);
      bus.botao = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.botao = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    check_state("glitch", 0, 3, 1'b0, 1'b0);
    push_exp(1'b1, 0, 2, 1'b0, 1'b0);
    apply_stimulus(3'd4, 3'd6, 1'b0, 6);
    check_state("press6", 0, 2, 1'b0, 1'b0);

    // Leaving attack mode mid-press discards the shot and keeps the score
    set_coord(3'd0, 3'd1, 1'b1);
    bus.botao = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.ch6 = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.botao = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_state("modo_off", 0, 2, 1'b0, 1'b0);
    bus.ch6 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_exp(1'b1, 1, 1, 1'b0, 1'b0);
    apply_stimulus(3'd0, 3'd1, 1'b1, 10);

    // Reset during a held press: cleared, and the held press is never accepted
    set_coord(3'd0, 3'd0, 1'b1);
    bus.botao = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_state("reset_held", 0, 3, 1'b0, 1'b0);
    bus.botao = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    push_exp(1'b1, 1, 2, 1'b0, 1'b0);
    apply_stimulus(3'd0, 3'd0, 1'b1, 10);
    check_state("final", 1, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
